// File: rtl/mem_block_pingpong_if.sv
// Write/read bus of the ping-pong line buffer; master drives writes and reads,
// slave is the buffer.
interface mem_block_pingpong_if #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
);
  localparam int unsigned LineW = LANES * 2 * DATA_WIDTH;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LANES-1:0]      wr_mask;
  logic [LineW-1:0]      wr_data;
  logic                  wr_last;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LineW-1:0]      rd_data;
  logic                  rd_valid;
  logic                  rd_bank_avail;
  logic                  rd_release;
  logic                  wr_bank;
  logic                  rd_bank;

  modport master (
    output wr_valid, wr_addr, wr_mask, wr_data, wr_last, rd_req, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_valid, rd_bank_avail, wr_bank, rd_bank
  );

  modport slave (
    input  wr_valid, wr_addr, wr_mask, wr_data, wr_last, rd_req, rd_addr, rd_release,
    output wr_ready, rd_data, rd_valid, rd_bank_avail, wr_bank, rd_bank
  );
endinterface

// File: rtl/mem_block_pingpong.sv
// Two-bank ping-pong line buffer with per-lane write masks and a registered read port.
// Define MEM_BLOCK_PINGPONG_OUT_REG_EN to add an output register (read latency 2).
module mem_block_pingpong #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input logic                   clk,
  input logic                   reset,
  mem_block_pingpong_if.slave   bus
);
  localparam int unsigned CompW = 2 * DATA_WIDTH;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned LineW = LANES * CompW;

  logic [CompW-1:0] ram [2][LANES][Depth];

  logic [1:0]       full_q, full_d;
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic             rd_valid_q, rd_valid_d;
  logic [LineW-1:0] rd_data_q, rd_data_d;
  logic [LineW-1:0] rd_line;
  logic             wr_ready, rd_avail;
  logic             wr_fire, rd_fire, rel_fire;

  assign wr_ready = ~full_q[wp_q];
  assign rd_avail = full_q[rp_q];
  assign wr_fire  = bus.wr_valid & wr_ready;
  assign rd_fire  = bus.rd_req & rd_avail;
  assign rel_fire = bus.rd_release & rd_avail;

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_bank_avail = rd_avail;
  assign bus.wr_bank       = wp_q;
  assign bus.rd_bank       = rp_q;

  // Commit and release can never hit the same bank: a committing bank is EMPTY,
  // a releasing one is FULL.
  always_comb begin
    full_d = full_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (wr_fire && bus.wr_last) begin
      full_d[wp_q] = 1'b1;
      wp_d         = ~wp_q;
    end
    if (rel_fire) begin
      full_d[rp_q] = 1'b0;
      rp_d         = ~rp_q;
    end
  end

  always_comb begin
    rd_line = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_line[k*CompW +: CompW] = ram[rp_q][k][bus.rd_addr];
    end
  end

  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_line : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q     <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      full_q     <= full_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_fire && bus.wr_mask[k]) begin
        ram[wp_q][k][bus.wr_addr] <= bus.wr_data[k*CompW +: CompW];
      end
    end
  end

`ifdef MEM_BLOCK_PINGPONG_OUT_REG_EN
  logic             out_valid_q, out_valid_d;
  logic [LineW-1:0] out_data_q, out_data_d;

  always_comb begin
    out_valid_d = rd_valid_q;
    out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.rd_valid = out_valid_q;
  assign bus.rd_data  = out_data_q;
`else
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
`endif
endmodule
